register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 17 +
 rtl/register_file_dump_fsm.sv | 114 +++++++++++
 rtl/register_file.sv | 94 +++++++++
 tb/tb_register_file.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared core package for the register file slice.
// Holds the architectural sizes, the register-index width and the state
// encoding of the register-dump FSM, so the storage block and the dump
// controller agree on them.
package register_file_pkg;

    localparam int XLEN_DEFAULT = 32;  // data width of every register
    localparam int NREG_DEFAULT = 32;  // number of architectural registers
    localparam int REG_IDX_W    = 5;   // register index width

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/register_file_dump_fsm.sv
// regfile_dump_fsm
// Streams every architectural register out over a valid/ready channel.
// The FSM owns the state, the beat index and the beat data register. It
// does not touch storage: it reports which index it will load next
// (load_idx) and the parent returns the bypassed value of that index
// (load_value), so a write landing on the loading cycle is captured.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   dump_start      request a full dump (ignored unless IDLE)
//   dump_ready      consumer accepts the current beat
//   load_value      bypassed register value for load_idx
//   load_idx        index whose value is captured on the next load
//   dump_valid      beat available (registered)
//   dump_idx        index of the current beat
//   dump_data       value of the current beat
//   dump_busy       high while not IDLE (registered)
//   dump_done       one-cycle pulse after the last beat is accepted
module regfile_dump_fsm
    import register_file_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dump_start,
    input  logic                 dump_ready,
    input  logic [XLEN-1:0]      load_value,
    output logic [REG_IDX_W-1:0] load_idx,
    output logic                 dump_valid,
    output logic [REG_IDX_W-1:0] dump_idx,
    output logic [XLEN-1:0]      dump_data,
    output logic                 dump_busy,
    output logic                 dump_done
);

    localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NREG - 1);

    dump_state_t            state_reg;
    logic [REG_IDX_W-1:0]   idx_reg;
    logic [XLEN-1:0]        data_reg;
    logic                   valid_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   handshake;

    assign handshake = valid_reg && dump_ready;

    // Starting a dump loads index 0; every later load is the successor of
    // the beat currently on the bus.
    always_comb begin
        load_idx = '0;
        if (state_reg != DUMP_IDLE) begin
            load_idx = idx_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= DUMP_IDLE;
            idx_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                DUMP_IDLE: begin
                    done_reg <= 1'b0;
                    if (dump_start) begin
                        state_reg <= DUMP_SEND;
                        idx_reg   <= '0;
                        data_reg  <= load_value;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                DUMP_SEND: begin
                    // Without a handshake idx/data hold, even if the
                    // register they mirror is rewritten meanwhile.
                    if (handshake) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= DUMP_DONE;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg  <= load_idx;
                            data_reg <= load_value;
                        end
                    end
                end
                DUMP_DONE: begin
                    state_reg <= DUMP_IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= DUMP_IDLE;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_valid = valid_reg;
    assign dump_idx   = idx_reg;
    assign dump_data  = data_reg;
    assign dump_busy  = busy_reg;
    assign dump_done  = done_reg;

endmodule

// File: rtl/register_file.sv
// register_file
// Two-read, one-write architectural register file with write-back bypass
// on the read ports and a streaming dump port for debug/checkpointing.
// x0 is hard-wired to zero: writes to it are dropped and it reads 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reg_write, rd_register,
//   write_data               write-back port
//   rs1_addr/rs1_data,
//   rs2_addr/rs2_data        combinational read ports (bypassed)
//   dump_start, dump_ready,
//   dump_valid, dump_idx,
//   dump_data, dump_busy,
//   dump_done                register dump stream, see regfile_dump_fsm
module register_file
    import register_file_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_write,
    input  logic [REG_IDX_W-1:0] rd_register,
    input  logic [XLEN-1:0]      write_data,
    input  logic [REG_IDX_W-1:0] rs1_addr,
    input  logic [REG_IDX_W-1:0] rs2_addr,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    input  logic                 dump_start,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [REG_IDX_W-1:0] dump_idx,
    output logic [XLEN-1:0]      dump_data,
    output logic                 dump_busy,
    output logic                 dump_done
);

    logic [XLEN-1:0]      regs_reg [NREG];
    logic [REG_IDX_W-1:0] load_idx;
    logic [XLEN-1:0]      load_value;

    // Bypassed read of one index: x0 is always 0, a same-cycle write-back
    // to the index wins over the stored value, and indices beyond NREG
    // read as 0.
    function automatic logic [XLEN-1:0] bypass_read(input logic [REG_IDX_W-1:0] addr);
        logic [XLEN-1:0] value;
        value = '0;
        if (addr != '0 && int'(addr) < NREG) begin
            if (reg_write && rd_register == addr) begin
                value = write_data;
            end else begin
                value = regs_reg[addr];
            end
        end
        return value;
    endfunction

    // Entry 0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (reg_write && rd_register != '0 && int'(rd_register) < NREG) begin
            regs_reg[rd_register] <= write_data;
        end
    end

    always_comb begin
        rs1_data   = bypass_read(rs1_addr);
        rs2_data   = bypass_read(rs2_addr);
        load_value = bypass_read(load_idx);
    end

    regfile_dump_fsm #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_dump_fsm (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .load_value (load_value),
        .load_idx   (load_idx),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed testbench for register_file: write/read, bypass, x0, full dump,
// stalled dump with a write to the held register, reset mid-dump.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic [4:0]  rd_register;
    logic [31:0] write_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        dump_start;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_busy;
    logic        dump_done;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_regs [32];

    register_file #(
        .XLEN (32),
        .NREG (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_write   (reg_write),
        .rd_register (rd_register),
        .write_data  (write_data),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .dump_start  (dump_start),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_idx    (dump_idx),
        .dump_data   (dump_data),
        .dump_busy   (dump_busy),
        .dump_done   (dump_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s value=0x%08h", tag, got);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] value);
        reg_write   = 1'b1;
        rd_register = idx;
        write_data  = value;
        tick();
        reg_write   = 1'b0;
    endtask

    task automatic start_dump();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    initial begin
        logic seen_done;
        rst         = 1'b0;
        reg_write   = 1'b0;
        rd_register = '0;
        write_data  = '0;
        rs1_addr    = 5'd5;
        rs2_addr    = '0;
        dump_start  = 1'b0;
        dump_ready  = 1'b1;
        for (int i = 0; i < 32; i++) exp_regs[i] = '0;

        // Reset state
        #2 rst = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_busy",  32'(dump_busy),  32'd0);
        check("rst_done",  32'(dump_done),  32'd0);
        check("rst_rs1",   rs1_data,        32'd0);
        check("rst_idx",   32'(dump_idx),   32'd0);
        rst = 1'b0;
        tick();

        // Write x5, bypass in the write cycle, stored value next cycle
        reg_write = 1'b1; rd_register = 5'd5; write_data = 32'hDEADBEEF;
        rs1_addr = 5'd5;
        #1 check("x5_bypass", rs1_data, 32'hDEADBEEF);
        tick();
        reg_write = 1'b0;
        #1 check("x5_stored", rs1_data, 32'hDEADBEEF);

        // Same-cycle bypass on port 2
        reg_write = 1'b1; rd_register = 5'd7; write_data = 32'h12345678;
        rs2_addr = 5'd7; rs1_addr = 5'd5;
        #1 check("x7_bypass_rs2", rs2_data, 32'h12345678);
        check("rs1_unaffected", rs1_data, 32'hDEADBEEF);
        tick();
        reg_write = 1'b0; rs1_addr = 5'd7;
        #1 check("x7_rs1_same", rs1_data, 32'h12345678);
        check("x7_rs2_same", rs2_data, 32'h12345678);

        // x0 is never written and reads 0
        reg_write = 1'b1; rd_register = 5'd0; write_data = 32'hFFFFFFFF;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1 check("x0_rs1_same", rs1_data, 32'd0);
        check("x0_rs2_same", rs2_data, 32'd0);
        tick();
        reg_write = 1'b0;
        #1 check("x0_rs1_after", rs1_data, 32'd0);

        // Preload xN = N*0x11
        for (int n = 1; n < 32; n++) begin
            write_reg(5'(n), 32'(n * 32'h11));
            exp_regs[n] = 32'(n * 32'h11);
        end

        // Full dump, ready held high. A write to x9 lands on the cycle x9
        // is loaded (beat 8 on the bus) and must be captured; a dump_start
        // pulse mid-dump must be ignored.
        dump_ready = 1'b1;
        start_dump();
        for (int b = 0; b < 32; b++) begin
            check($sformatf("d1_valid_%0d", b), 32'(dump_valid), 32'd1);
            check($sformatf("d1_idx_%0d", b),   32'(dump_idx),   32'(b));
            check($sformatf("d1_data_%0d", b),  dump_data,       exp_regs[b]);
            if (b == 8) begin
                reg_write = 1'b1; rd_register = 5'd9; write_data = 32'h99999999;
                exp_regs[9] = 32'h99999999;
            end
            if (b == 5) dump_start = 1'b1;
            tick();
            reg_write  = 1'b0;
            dump_start = 1'b0;
        end
        check("d1_done_pulse", 32'(dump_done),  32'd1);
        check("d1_done_busy",  32'(dump_busy),  32'd1);
        check("d1_done_valid", 32'(dump_valid), 32'd0);
        tick();
        check("d1_done_clear", 32'(dump_done),  32'd0);
        check("d1_idle_busy",  32'(dump_busy),  32'd0);

        // Stall at idx 3 while rewriting x3
        start_dump();
        tick(); tick(); tick();
        check("d2_idx3", 32'(dump_idx), 32'd3);
        dump_ready = 1'b0;
        reg_write = 1'b1; rd_register = 5'd3; write_data = 32'hCAFE0000;
        tick();
        reg_write = 1'b0;
        exp_regs[3] = 32'hCAFE0000;
        check("d2_stall_idx",   32'(dump_idx),   32'd3);
        check("d2_stall_data",  dump_data,       32'h33);
        check("d2_stall_valid", 32'(dump_valid), 32'd1);
        tick();
        check("d2_stall2_data", dump_data,       32'h33);
        rs1_addr = 5'd3;
        #1 check("d2_x3_written", rs1_data, 32'hCAFE0000);
        dump_ready = 1'b1;
        tick();
        check("d2_release_idx",  32'(dump_idx), 32'd4);
        check("d2_release_data", dump_data,     32'h44);
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            tick();
            if (dump_done) seen_done = 1'b1;
        end
        check("d2_done_seen", 32'(seen_done), 32'd1);
        tick();
        check("d2_idle_busy", 32'(dump_busy), 32'd0);

        // Reset in the middle of a dump
        start_dump();
        for (int c = 0; c < 10; c++) tick();
        check("d3_idx10", 32'(dump_idx), 32'd10);
        rs1_addr = 5'd10;
        #1 check("d3_x10_before", rs1_data, 32'hAA);
        #1 rst = 1'b1;
        #1;
        check("d3_rst_busy",  32'(dump_busy),  32'd0);
        check("d3_rst_valid", 32'(dump_valid), 32'd0);
        check("d3_rst_idx",   32'(dump_idx),   32'd0);
        check("d3_rst_data",  dump_data,       32'd0);
        check("d3_rst_x10",   rs1_data,        32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("d3_rst_done_%0d", c), 32'(dump_done), 32'd0);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("d3_post_done_%0d", c), 32'(dump_done), 32'd0);
            check($sformatf("d3_post_busy_%0d", c), 32'(dump_busy), 32'd0);
        end
        rs1_addr = 5'd10; rs2_addr = 5'd5;
        #1 check("d3_post_x10", rs1_data, 32'd0);
        check("d3_post_x5", rs2_data, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
